if_fetch_queue: RTL
===================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, fetch address after reset.
REQ-002 Parameter QDEPTH, default 2, prefetch queue entries (legal range 2..4).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  16  byte address of the requested instruction word.
REQ-007 imem_ack  input  1  read complete; imem_data valid this cycle.
REQ-008 imem_data  input  16  instruction word returned with imem_ack.
REQ-009 redirect  input  1  taken branch/jump from the ID comparator; flush and refetch.
REQ-010 redirect_pc  input  16  target address, sampled when redirect=1.
REQ-011 stall  input  1  IF/ID hold from the hazard unit; head entry is not consumed.
REQ-012 ifid_valid  output  1  head queue entry presented to IF/ID.
REQ-013 ifid_instr  output  16  head instruction; 16'h0000 when ifid_valid=0.
REQ-014 ifid_pc_plus2  output  16  fetch address of head entry plus 2; 16'h0000 when ifid_valid=0.

Function
REQ-015 States: IDLE (no request outstanding), WAIT (request outstanding), DISCARD (outstanding request whose data is dropped).
REQ-016 At most one request is outstanding; imem_req=1 exactly in WAIT and DISCARD; imem_addr is held stable until imem_ack.
REQ-017 IDLE -> WAIT when count + 0 < QDEPTH after this cycle's pop; imem_addr = fetch_pc.
REQ-018 WAIT with imem_ack: push {imem_data, fetch_pc+2}, fetch_pc <= fetch_pc+2; next state WAIT at the new fetch_pc if count after push and pop < QDEPTH, else IDLE.
REQ-019 An outstanding request reserves a slot: a push never occurs into a full queue.
REQ-020 Pop occurs when ifid_valid=1 and stall=0; the next entry (if any) is presented the following cycle.
REQ-021 Push and pop in the same cycle leave count unchanged and preserve FIFO order.
REQ-022 redirect has priority over stall, ack and pop: queue count <= 0, fetch_pc <= redirect_pc, ifid_valid=0 on the following cycle.
REQ-023 redirect in WAIT without imem_ack -> DISCARD; the next imem_ack is dropped, then WAIT at redirect_pc.
REQ-024 redirect coincident with imem_ack in WAIT -> data dropped, next state WAIT at redirect_pc.
REQ-025 redirect in DISCARD updates the target only; state remains DISCARD.
REQ-026 redirect in IDLE -> WAIT at redirect_pc next cycle.
REQ-027 imem_ack in IDLE is ignored.
REQ-028 Address arithmetic is modulo 2^16: fetch_pc 16'hFFFE advances to 16'h0000; ifid_pc_plus2 wraps identically.
REQ-029 Minimum latency: request issued cycle N, ack in cycle N -> ifid_valid=1 in cycle N+1.
REQ-030 Sustained throughput with single-cycle ack and stall=0 is one instruction per cycle.

Reset
REQ-031 reset=1: state IDLE, count 0, fetch_pc RESET_PC, imem_req 0, ifid_valid 0, ifid_instr 16'h0000, ifid_pc_plus2 16'h0000.
REQ-032 reset overrides redirect, stall and imem_ack; reset mid-request abandons it, and a late ack arriving in IDLE is ignored.
REQ-033 First request, at RESET_PC, is issued the cycle after reset deasserts.

Verification
REQ-034 Memory with single-cycle ack, stall=0, words at 0x0,0x2,0x4 = 1111,2222,3333 -> ifid_instr 1111,2222,3333 on consecutive cycles, pc_plus2 0002,0004,0006.
REQ-035 stall=1 for 4 cycles with QDEPTH=2 -> ifid_instr held, imem_req low once 2 entries are queued, no entry lost or duplicated after release.
REQ-036 3-cycle ack latency, redirect to 0x0040 in the first wait cycle -> stale ack dropped, next imem_addr 0x0040, first valid instr is mem[0x40].
REQ-037 redirect to 0x0100 coincident with ack while 2 entries are queued -> ifid_valid=0 next cycle, then mem[0x100] with pc_plus2 0x0102.
REQ-038 RESET_PC=16'hFFFE -> fetches 0xFFFE then 0x0000; pc_plus2 values 0x0000, 0x0002.
REQ-039 reset asserted in WAIT, ack one cycle after deassert -> ack ignored, fresh request at RESET_PC, ifid_valid stays 0 until that request's ack.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction fetch unit with a small prefetch queue feeding IF/ID.
// One memory request outstanding at a time; redirects flush the queue and drop in-flight data.
module if_fetch_queue #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic        ifid_valid,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2
);

    localparam int PW = (QDEPTH > 2) ? 2 : 1;
    localparam logic [2:0] QD = 3'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [15:0]     fetch_pc_r, fetch_pc_s;
    logic [15:0]     addr_r, addr_s;
    logic [2:0]      count_r, count_s, count_pop_s;
    logic [PW-1:0]   rd_ptr_r, wr_ptr_r;
    logic [15:0]     q_instr_r [QDEPTH];
    logic [15:0]     q_pc2_r   [QDEPTH];
    logic            push_s, pop_s, flush_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(QDEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Next-state, queue control and the next request address
    always_comb begin
        state_s     = state_r;
        fetch_pc_s  = fetch_pc_r;
        addr_s      = addr_r;
        push_s      = 1'b0;
        flush_s     = 1'b0;
        pop_s       = (count_r != 3'd0) && !stall && !redirect;
        count_pop_s = count_r - {2'b00, pop_s};
        case (state_r)
            IDLE: begin
                if (redirect) begin
                    flush_s    = 1'b1;
                    fetch_pc_s = redirect_pc;
                    addr_s     = redirect_pc;
                    state_s    = WAIT;
                end else if (count_pop_s < QD) begin
                    addr_s  = fetch_pc_r;
                    state_s = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (redirect) begin
                    flush_s    = 1'b1;
                    fetch_pc_s = redirect_pc;
                    if (imem_ack) begin
                        addr_s  = redirect_pc;
                        state_s = WAIT;
                    end else begin
                        state_s = DISCARD;
                    end
                end else if (imem_ack) begin
                    push_s     = 1'b1;
                    fetch_pc_s = fetch_pc_r + 16'd2;
                    // the slot for the next request must survive this cycle's push
                    if ((count_pop_s + 3'd1) < QD) begin
                        addr_s  = fetch_pc_r + 16'd2;
                        state_s = WAIT;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    flush_s    = 1'b1;
                    fetch_pc_s = redirect_pc;
                    if (imem_ack) begin
                        addr_s  = redirect_pc;
                        state_s = WAIT;
                    end else begin
                        state_s = DISCARD;
                    end
                end else if (imem_ack) begin
                    addr_s  = fetch_pc_r;
                    state_s = WAIT;
                end else begin
                    state_s = DISCARD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        if (flush_s) begin
            count_s = 3'd0;
        end else begin
            count_s = count_pop_s + {2'b00, push_s};
        end
    end

    // Control state, fetch pointer and queue pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            addr_r     <= RESET_PC;
            count_r    <= 3'd0;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            addr_r     <= addr_s;
            count_r    <= count_s;
            if (flush_s) begin
                rd_ptr_r <= '0;
                wr_ptr_r <= '0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= ptr_inc(wr_ptr_r);
                end
                if (pop_s) begin
                    rd_ptr_r <= ptr_inc(rd_ptr_r);
                end
            end
        end
    end

    // Queue payload storage; contents are only visible through a valid count
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            q_instr_r[wr_ptr_r] <= imem_data;
            q_pc2_r[wr_ptr_r]   <= fetch_pc_r + 16'd2;
        end
    end

    assign imem_req      = (state_r != IDLE);
    assign imem_addr     = addr_r;
    assign ifid_valid    = (count_r != 3'd0);
    assign ifid_instr    = ifid_valid ? q_instr_r[rd_ptr_r] : 16'h0000;
    assign ifid_pc_plus2 = ifid_valid ? q_pc2_r[rd_ptr_r]   : 16'h0000;

endmodule
